// File: rtl/ram_drain.sv
// Drains a completed page from NUM_BANK byte-wide RAM banks onto a valid/ready line stream.
// Optional feature macro RAM_CLEAR_EN: clear each line's valid flags as its read data returns.
module ram_drain #(
  parameter int NUM_BANK = 16,
  parameter int ADDR_W   = 12,
  parameter int RD_LAT   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  page_finish,
  input  logic [ADDR_W+4:0]     page_len,
  output logic                  rd_en,
  output logic [ADDR_W-1:0]     rd_addr,
  input  logic [NUM_BANK*8-1:0] rd_data,
  output logic                  ram_clr_en,
  output logic [ADDR_W-1:0]     ram_clr_addr,
  output logic [NUM_BANK*8-1:0] dout,
  output logic [NUM_BANK-1:0]   dout_keep,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic                  dout_last,
  output logic                  cl_finish
);
  localparam int DW    = NUM_BANK * 8;
  localparam int LW    = ADDR_W + 1;
  localparam int BW    = $clog2(NUM_BANK);
  localparam int DEPTH = (RD_LAT + 2 > 4) ? RD_LAT + 2 : 4;
  localparam int PW    = $clog2(DEPTH);
  localparam int CW    = $clog2(DEPTH + 1);
  localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_DRAIN, ST_DONE} state_t;

  state_t              state_r;
  logic [LW-1:0]       lines_r;
  logic [BW-1:0]       tail_r;
  logic [LW-1:0]       rd_cnt_r;
  logic                armed_r;
  logic [CW-1:0]       infl_r;
  logic [RD_LAT-1:0]   pipe_vld_r;
  logic [ADDR_W-1:0]   pipe_tag_r [RD_LAT];
  logic [DW-1:0]       fifo_data_r [DEPTH];
  logic [NUM_BANK-1:0] fifo_keep_r [DEPTH];
  logic                fifo_last_r [DEPTH];
  logic [PW-1:0]       wr_ptr_r;
  logic [PW-1:0]       rd_ptr_r;
  logic [CW-1:0]       cnt_r;

  logic [LW-1:0]       lines_s;
  logic [CW:0]         occ_s;
  logic                start_s;
  logic                issue_s;
  logic                push_s;
  logic                pop_s;
  logic                push_last_s;
  logic [NUM_BANK-1:0] push_keep_s;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) begin
      return '0;
    end else begin
      return p + PW'(1);
    end
  endfunction

  // Page sizing, read credit and the per-line keep/last tags for the returning data
  always_comb begin
    lines_s     = LW'(page_len >> BW) + LW'(|page_len[BW-1:0]);
    start_s     = (state_r == ST_IDLE) && page_finish && armed_r;
    occ_s       = {1'b0, cnt_r} + {1'b0, infl_r};
    issue_s     = (state_r == ST_READ) && (occ_s < DEPTH_C);
    push_s      = pipe_vld_r[RD_LAT-1];
    pop_s       = (cnt_r != '0) && dout_ready;
    push_last_s = ({1'b0, pipe_tag_r[RD_LAT-1]} == (lines_r - LW'(1)));
    if (push_last_s && (tail_r != '0)) begin
      push_keep_s = ~({NUM_BANK{1'b1}} << tail_r);
    end else begin
      push_keep_s = {NUM_BANK{1'b1}};
    end
  end

  // Page control FSM: sizing, read address counter and restart interlock
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ST_IDLE;
      lines_r  <= '0;
      tail_r   <= '0;
      rd_cnt_r <= '0;
      armed_r  <= 1'b1;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (!page_finish) armed_r <= 1'b1;
          if (start_s) begin
            lines_r  <= lines_s;
            tail_r   <= page_len[BW-1:0];
            rd_cnt_r <= '0;
            state_r  <= (page_len == '0) ? ST_DONE : ST_READ;
          end
        end
        ST_READ: begin
          if (issue_s) begin
            rd_cnt_r <= rd_cnt_r + LW'(1);
            if (rd_cnt_r == (lines_r - LW'(1))) state_r <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (pop_s && dout_last && (infl_r == '0) && (cnt_r == CW'(1))) state_r <= ST_DONE;
        end
        ST_DONE: begin
          armed_r <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  // Read-latency delay line: each issued read arrives at its tail exactly RD_LAT cycles later
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_vld_r <= '0;
      infl_r     <= '0;
      for (int i = 0; i < RD_LAT; i++) pipe_tag_r[i] <= '0;
    end else begin
      pipe_vld_r[0] <= issue_s;
      pipe_tag_r[0] <= rd_cnt_r[ADDR_W-1:0];
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_vld_r[i] <= pipe_vld_r[i-1];
        pipe_tag_r[i] <= pipe_tag_r[i-1];
      end
      infl_r <= infl_r + CW'(issue_s) - CW'(push_s);
    end
  end

  // Output FIFO pointers and occupancy; credit on the read side keeps pushes from overflowing
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      cnt_r    <= '0;
    end else begin
      if (push_s) wr_ptr_r <= next_ptr(wr_ptr_r);
      if (pop_s)  rd_ptr_r <= next_ptr(rd_ptr_r);
      cnt_r <= cnt_r + CW'(push_s) - CW'(pop_s);
    end
  end

  // Output FIFO storage
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_data_r[wr_ptr_r] <= rd_data;
      fifo_keep_r[wr_ptr_r] <= push_keep_s;
      fifo_last_r[wr_ptr_r] <= push_last_s;
    end
  end

  assign rd_en      = issue_s;
  assign rd_addr    = issue_s ? rd_cnt_r[ADDR_W-1:0] : '0;
  assign dout_valid = (cnt_r != '0);
  assign dout       = dout_valid ? fifo_data_r[rd_ptr_r] : '0;
  assign dout_keep  = dout_valid ? fifo_keep_r[rd_ptr_r] : '0;
  assign dout_last  = dout_valid ? fifo_last_r[rd_ptr_r] : 1'b0;
  assign cl_finish  = (state_r == ST_DONE);

`ifdef RAM_CLEAR_EN
  assign ram_clr_en   = pipe_vld_r[RD_LAT-1];
  assign ram_clr_addr = pipe_vld_r[RD_LAT-1] ? pipe_tag_r[RD_LAT-1] : '0;
`else
  assign ram_clr_en   = 1'b0;
  assign ram_clr_addr = '0;
`endif

endmodule

// File: tb/tb_ram_drain.sv
// Randomized bench for ram_drain: a delayed-response RAM model feeds the DUT and a
// beat-level scoreboard checks every output cycle against the expected page contents.
module tb_ram_drain;
  localparam int NB  = 16;
  localparam int AW  = 12;
  localparam int RL  = 2;
  localparam int DW  = NB * 8;
  localparam int PLW = AW + 5;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            page_finish;
  logic [PLW-1:0]  page_len;
  logic            rd_en;
  logic [AW-1:0]   rd_addr;
  logic [DW-1:0]   rd_data;
  logic            ram_clr_en;
  logic [AW-1:0]   ram_clr_addr;
  logic [DW-1:0]   dout;
  logic [NB-1:0]   dout_keep;
  logic            dout_valid;
  logic            dout_ready;
  logic            dout_last;
  logic            cl_finish;

  ram_drain #(.NUM_BANK(NB), .ADDR_W(AW), .RD_LAT(RL)) dut (
    .clk(clk), .rst_n(rst_n), .page_finish(page_finish), .page_len(page_len),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .ram_clr_en(ram_clr_en), .ram_clr_addr(ram_clr_addr),
    .dout(dout), .dout_keep(dout_keep), .dout_valid(dout_valid),
    .dout_ready(dout_ready), .dout_last(dout_last), .cl_finish(cl_finish)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] d;
    logic [NB-1:0] k;
    logic          l;
  } beat_t;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  logic [DW-1:0] mem [1 << AW];
  beat_t exp_q[$];
  logic [NB-1:0] acc_keep[$];
  int rd_next = 0, rd_lines = 0, fin_due = -1, fin_seen = 0;
  int acc_beats = 0, first_vld = -1, last_pop = -1, ready_mode = 0;
  logic hist_v [RL];
  logic [AW-1:0] hist_a [RL];
  logic clr_v;
  logic [AW-1:0] clr_a;
  logic prev_stall = 1'b0;
  logic [DW-1:0] prev_dout;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // RAM model: answers each read exactly RL cycles later, garbage otherwise; drives dout_ready
  initial begin
    rd_data = '0;
    dout_ready = 1'b1;
    clr_v = 1'b0;
    clr_a = '0;
    for (int i = 0; i < RL; i++) begin hist_v[i] = 1'b0; hist_a[i] = '0; end
    forever begin
      @(negedge clk);
      case (ready_mode)
        0:       dout_ready = 1'b1;
        1:       dout_ready = (cyc % 4 == 0);
        default: dout_ready = 1'($urandom_range(0, 1));
      endcase
      if (!rst_n) begin
        for (int i = 0; i < RL; i++) begin hist_v[i] = 1'b0; hist_a[i] = '0; end
        clr_v = 1'b0;
        rd_data = {$urandom(), $urandom(), $urandom(), $urandom()};
      end else begin
        clr_v = hist_v[RL-1];
        clr_a = hist_a[RL-1];
        rd_data = clr_v ? mem[clr_a] : {$urandom(), $urandom(), $urandom(), $urandom()};
        for (int i = RL - 1; i > 0; i--) begin hist_v[i] = hist_v[i-1]; hist_a[i] = hist_a[i-1]; end
        hist_v[0] = rd_en;
        hist_a[0] = rd_addr;
      end
    end
  end

  // Compare process: every cycle, DUT outputs against the scoreboard
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n) begin
        chk("reset_ctrl", {rd_en, ram_clr_en, dout_valid, dout_last, cl_finish, rd_addr, ram_clr_addr, dout_keep}, '0);
        chk("reset_dout", dout, '0);
        prev_stall = 1'b0;
      end else begin
        if (rd_en) begin
          chk("rd_en_in_page", rd_en, (rd_next < rd_lines));
          chk("rd_addr", rd_addr, rd_next[AW-1:0]);
          rd_next++;
        end
`ifdef RAM_CLEAR_EN
        chk("clr_en", ram_clr_en, clr_v);
        if (clr_v) chk("clr_addr", ram_clr_addr, clr_a);
`else
        chk("clr_off", {ram_clr_en, ram_clr_addr}, '0);
`endif
        chk("cl_finish", cl_finish, (cyc == fin_due));
        if (cl_finish) fin_seen++;
        if (prev_stall) begin
          chk("stall_valid", dout_valid, 1'b1);
          chk("stall_dout", dout, prev_dout);
        end
        if (dout_valid) begin
          if (exp_q.size() == 0) begin
            chk("spurious_valid", dout_valid, 1'b0);
          end else begin
            if (first_vld < 0) first_vld = cyc;
            chk("dout", dout, exp_q[0].d);
            chk("keep", dout_keep, exp_q[0].k);
            chk("last", dout_last, exp_q[0].l);
            if (dout_ready) begin
              acc_keep.push_back(dout_keep);
              acc_beats++;
              last_pop = cyc;
              if (exp_q[0].l) fin_due = cyc + 1;
              void'(exp_q.pop_front());
            end
          end
        end
        prev_stall = dout_valid && !dout_ready;
        prev_dout = dout;
      end
    end
  end

  task automatic load_page(input int len);
    int lines;
    int tail;
    lines = (len + NB - 1) / NB;
    tail = len % NB;
    exp_q.delete();
    acc_keep.delete();
    acc_beats = 0; first_vld = -1; last_pop = -1; fin_seen = 0;
    for (int i = 0; i < lines; i++) begin
      beat_t b;
      b.d = {$urandom(), $urandom(), $urandom(), $urandom()};
      mem[i] = b.d;
      b.l = (i == lines - 1);
      b.k = (b.l && tail != 0) ? NB'((1 << tail) - 1) : {NB{1'b1}};
      exp_q.push_back(b);
    end
    rd_next = 0;
    rd_lines = lines;
  endtask

  task automatic run_page(input int len, input int mode, input bit hold,
                          output int beats, output int lat, output int span);
    int start;
    int t;
    ready_mode = mode;
    load_page(len);
    @(negedge clk);
    start = cyc;
    if (len == 0) fin_due = cyc + 1;
    page_len = PLW'(len);
    page_finish = 1'b1;
    @(negedge clk);
    page_len = PLW'($urandom());
    t = 0;
    while (fin_seen == 0 && t < 20000) begin @(negedge clk); t++; end
    if (fin_seen == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL finish_timeout: got no cl_finish required one (len %0d)", len);
    end
    if (hold) repeat (20) @(negedge clk);
    page_finish = 1'b0;
    repeat (3) @(negedge clk);
    beats = acc_beats;
    lat = first_vld - start;
    span = last_pop - first_vld;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int b, l, s, len, lines;
    rst_n = 1'b0; page_finish = 1'b0; page_len = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_page(40, 0, 1'b0, b, l, s);
    chk("p40_beats", b, 3);
    chk("p40_keep0", acc_keep[0], 16'hFFFF);
    chk("p40_keep1", acc_keep[1], 16'hFFFF);
    chk("p40_keep2", acc_keep[2], 16'h00FF);
    chk("p40_finish_count", fin_seen, 1);
    chk("p40_latency", l, RL + 2);
    chk("p40_throughput", s, 2);

    run_page(0, 0, 1'b0, b, l, s);
    chk("p0_beats", b, 0);
    chk("p0_finish_count", fin_seen, 1);

    run_page(160, 1, 1'b0, b, l, s);
    chk("p160_beats", b, 10);
    chk("p160_keep_last", acc_keep[9], 16'hFFFF);

    run_page(32, 0, 1'b0, b, l, s);
    chk("p32_beats", b, 2);

    run_page(48, 0, 1'b1, b, l, s);
    chk("hold_beats", b, 3);
    chk("hold_finish_count", fin_seen, 1);
    run_page(20, 2, 1'b0, b, l, s);
    chk("after_hold_beats", b, 2);
    chk("after_hold_keep_last", acc_keep[1], 16'h000F);

    // reset in the middle of a 64-line page
    ready_mode = 0;
    load_page(1024);
    @(negedge clk);
    page_len = PLW'(1024);
    page_finish = 1'b1;
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    page_finish = 1'b0;
    exp_q.delete(); rd_lines = 0; rd_next = 0; fin_due = -1; fin_seen = 0;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_no_finish", fin_seen, 0);
    run_page(100, 0, 1'b0, b, l, s);
    chk("post_reset_beats", b, 7);
    chk("post_reset_keep_last", acc_keep[6], 16'h000F);

    run_page(1, 0, 1'b0, b, l, s);
    chk("p1_keep", acc_keep[0], 16'h0001);
    run_page(17, 2, 1'b0, b, l, s);
    chk("p17_beats", b, 2);
    chk("p17_keep_last", acc_keep[1], 16'h0001);

    run_page(NB << AW, 0, 1'b0, b, l, s);
    chk("full_page_beats", b, 1 << AW);
    chk("full_page_latency", l, RL + 2);
    chk("full_page_throughput", s, (1 << AW) - 1);

    for (int i = 0; i < 8; i++) begin
      len = $urandom_range(1, 400);
      lines = (len + NB - 1) / NB;
      run_page(len, i % 3, 1'b0, b, l, s);
      chk("rand_beats", b, lines);
      chk("rand_finish_count", fin_seen, 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
